// File: rtl/stage_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB stage sequencer and PC unit for the Core Musa datapath.
// Instruction length varies by class; IF and MEM wait on mem_ready, halt parks the core.
module stage_sequencer #(
  parameter int unsigned           PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_ready,
  input  logic [1:0]          instr_class,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                halt,
  output logic [2:0]          stage,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] _npc1,
  output logic                fetch_req,
  output logic                mem_req,
  output logic                instr_done
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [1:0] C_ALU   = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc_q, pc_next;
  logic [PC_WIDTH-1:0] npc_q, npc_next;
  logic [1:0]          cls_q, cls_next;

  // State and PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IF;
      pc_q  <= RESET_PC;
      npc_q <= '0;
      cls_q <= '0;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
      npc_q <= npc_next;
      cls_q <= cls_next;
    end
  end

  // Next-state, PC update and request/done decode
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    npc_next   = npc_q;
    cls_next   = cls_q;
    fetch_req  = 1'b0;
    mem_req    = 1'b0;
    instr_done = 1'b0;

    case (state)
      S_IF: begin
        fetch_req = 1'b1;
        if (mem_ready) begin
          npc_next   = pc_q + PC_WIDTH'(4);
          state_next = S_ID;
        end
      end
      S_ID: begin
        cls_next   = instr_class;
        state_next = S_EX;
      end
      S_EX: begin
        case (cls_q)
          C_ALU:           state_next = S_WB;
          C_LOAD, C_STORE: state_next = S_MEM;
          default: begin
            instr_done = 1'b1;
            pc_next    = branch_taken ? {branch_target[PC_WIDTH-1:2], 2'b00} : npc_q;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          if (cls_q == C_LOAD) begin
            state_next = S_WB;
          end else begin
            instr_done = 1'b1;
            pc_next    = npc_q;
          end
        end
      end
      S_WB: begin
        instr_done = 1'b1;
        pc_next    = npc_q;
      end
      S_HALT: ;
      default: state_next = S_IF;
    endcase

    // Completion cycle is the only place halt is honoured
    if (instr_done) state_next = halt ? S_HALT : S_IF;
  end

  assign stage = state;
  assign pc    = pc_q;
  assign _npc1 = npc_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: each driven cycle pushes the expected
// outputs, and a negedge checker pops and compares them against the DUT.
module tb_stage_sequencer;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

  typedef struct {
    logic [2:0]  stage;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        done;
    bit          wrap;
    string       phase;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ready;
  logic [1:0]  instr_class;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;

  logic [2:0]  stage, w_stage;
  logic [31:0] pc, w_pc, npc1, w_npc1;
  logic        fetch_req, mem_req, instr_done;
  logic        w_fetch_req, w_mem_req, w_instr_done;

  exp_t  sb[$];
  exp_t  cur;
  string phase = "reset";
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc_n = 0;

  stage_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .instr_class(instr_class),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .stage(stage), .pc(pc), ._npc1(npc1), .fetch_req(fetch_req),
    .mem_req(mem_req), .instr_done(instr_done)
  );

  stage_sequencer #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .instr_class(instr_class),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .stage(w_stage), .pc(w_pc), ._npc1(w_npc1), .fetch_req(w_fetch_req),
    .mem_req(w_mem_req), .instr_done(w_instr_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s cycle=%0d got=%h expected=%h", phase, tag, cyc_n, got, exp);
    end
  endtask

  // Pop one expectation per cycle and compare mid-cycle
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      if (cur.wrap) begin
        check("w_stage", 32'(w_stage), 32'(cur.stage));
        check("w_pc", w_pc, cur.pc);
        check("w_npc1", w_npc1, cur.npc);
        check("w_done", 32'(w_instr_done), 32'(cur.done));
      end else begin
        check("stage", 32'(stage), 32'(cur.stage));
        check("pc", pc, cur.pc);
        check("npc1", npc1, cur.npc);
        check("fetch_req", 32'(fetch_req), 32'(cur.stage == S_IF));
        check("mem_req", 32'(mem_req), 32'(cur.stage == S_MEM));
        check("done", 32'(instr_done), 32'(cur.done));
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic cyc(input logic r, input logic mr, input logic [1:0] cls,
                     input logic bt, input logic [31:0] tgt, input logic h,
                     input logic [2:0] es, input logic [31:0] epc,
                     input logic [31:0] enpc, input logic ed, input bit w);
    exp_t e;
    rst = r; mem_ready = mr; instr_class = cls;
    branch_taken = bt; branch_target = tgt; halt = h;
    e.stage = es; e.pc = epc; e.npc = enpc; e.done = ed; e.wrap = w; e.phase = phase;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; instr_class = 2'd0;
    branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ALU stream; halt in ID ignored, halt in WB of second instruction parks
    phase = "alu_halt";
    cyc(0, 1, 0, 0, 0, 0, S_IF,   32'h0, 32'h0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, S_ID,   32'h0, 32'h4, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, S_EX,   32'h0, 32'h4, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, S_WB,   32'h0, 32'h4, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, S_IF,   32'h4, 32'h4, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, S_ID,   32'h4, 32'h8, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, S_EX,   32'h4, 32'h8, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, S_WB,   32'h4, 32'h8, 1, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 3, 1, 32'hFFF, i[0], S_HALT, 32'h8, 32'h8, 0, 0);
    phase = "rst_in_halt";
    cyc(1, 1, 0, 0, 0, 0, S_HALT, 32'h8, 32'h8, 0, 0);

    // LOAD with three MEM wait cycles, then STORE with two IF wait cycles
    phase = "load_stall";
    cyc(0, 1, 0, 0, 0, 0, S_IF,   32'h0, 32'h0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, S_ID,   32'h0, 32'h4, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, S_EX,   32'h0, 32'h4, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 0, 0, S_MEM, 32'h0, 32'h4, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, S_MEM,  32'h0, 32'h4, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, S_WB,   32'h0, 32'h4, 1, 0);
    phase = "store_ifwait";
    cyc(0, 0, 0, 0, 0, 0, S_IF,   32'h4, 32'h4, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, S_IF,   32'h4, 32'h4, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, S_IF,   32'h4, 32'h4, 0, 0);
    cyc(0, 1, 2, 0, 0, 0, S_ID,   32'h4, 32'h8, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, S_EX,   32'h4, 32'h8, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, S_MEM,  32'h4, 32'h8, 1, 0);

    // Not-taken then taken branch; ALU ignores branch_taken
    phase = "branch_nt";
    cyc(0, 1, 0, 0, 0, 0, S_IF,   32'h8, 32'h8, 0, 0);
    cyc(0, 1, 3, 0, 0, 0, S_ID,   32'h8, 32'hC, 0, 0);
    cyc(0, 1, 0, 0, 32'h103, 0, S_EX, 32'h8, 32'hC, 1, 0);
    phase = "branch_t";
    cyc(0, 1, 0, 0, 0, 0, S_IF,   32'hC, 32'hC, 0, 0);
    cyc(0, 1, 3, 0, 0, 0, S_ID,   32'hC, 32'h10, 0, 0);
    cyc(0, 1, 0, 1, 32'h103, 0, S_EX, 32'hC, 32'h10, 1, 0);
    phase = "alu_bt_ignored";
    cyc(0, 1, 0, 0, 0, 0, S_IF,   32'h100, 32'h10, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, S_ID,   32'h100, 32'h104, 0, 0);
    cyc(0, 1, 0, 1, 32'h555, 0, S_EX, 32'h100, 32'h104, 0, 0);
    cyc(0, 1, 0, 1, 32'h555, 0, S_WB, 32'h100, 32'h104, 1, 0);

    // Reset during a MEM stall
    phase = "rst_mem";
    cyc(0, 1, 0, 0, 0, 0, S_IF,   32'h104, 32'h104, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, S_ID,   32'h104, 32'h108, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, S_EX,   32'h104, 32'h108, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, S_MEM,  32'h104, 32'h108, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, S_MEM,  32'h104, 32'h108, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, S_IF,   32'h0, 32'h0, 0, 0);

    // PC wrap on the second instance (reset together with the first above)
    phase = "wrap";
    cyc(0, 1, 0, 0, 0, 0, S_IF,   32'hFFFF_FFFC, 32'h0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, S_ID,   32'hFFFF_FFFC, 32'h0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, S_EX,   32'hFFFF_FFFC, 32'h0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, S_WB,   32'hFFFF_FFFC, 32'h0, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, S_IF,   32'h0, 32'h0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, S_ID,   32'h0, 32'h4, 0, 1);

    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    n_fail++;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc_n);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
